dual_port_blockram: RTL and testbench

//   Simple dual-port block RAM: one write port and one independent read port, both on the same clock.

---
 rtl/dual_port_blockram_if.sv | 32 +++
 rtl/dual_port_blockram.sv | 211 +++++++++++++++++++++
 tb/tb_dual_port_blockram.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_blockram_if.sv
// Bus interface for dual_port_blockram: write port, read port and init status.
// The slave modport is the RAM side; the master modport is the requester side.
interface dual_port_blockram_if #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUMBER_SETS               = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUMBER_SETS),
    parameter int BYTE_SIZE_IN_BITS         = 8
);
    localparam int BYTES_PER_ENTRY = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_SIZE_IN_BITS;

    logic                                 init_done_out;
    logic                                 write_en_in;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     write_set_addr_in;
    logic [BYTES_PER_ENTRY-1:0]           write_byte_en_in;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in;
    logic                                 read_en_in;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     read_set_addr_in;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out;
    logic                                 read_valid_out;

    modport master (
        output write_en_in, write_set_addr_in, write_byte_en_in, write_entry_in,
        output read_en_in, read_set_addr_in,
        input  init_done_out, read_entry_out, read_valid_out
    );

    modport slave (
        input  write_en_in, write_set_addr_in, write_byte_en_in, write_entry_in,
        input  read_en_in, read_set_addr_in,
        output init_done_out, read_entry_out, read_valid_out
    );
endinterface

// File: rtl/dual_port_blockram.sv
// Simple dual-port block RAM (one write port, one read port, same clock) with
// per-byte write enables, read-valid pulse, 1- or 2-cycle read latency and a
// clear-on-reset sequencer that zeroes one entry per cycle before ports open.
// Optional feature macro: DUAL_PORT_BLOCKRAM_BYPASS_EN selects write-first
// behaviour for same-address read/write collisions (read-first when undefined).
module dual_port_blockram #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUMBER_SETS               = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUMBER_SETS),
    parameter int BYTE_SIZE_IN_BITS         = 8,
    parameter int READ_LATENCY              = 1
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    dual_port_blockram_if.slave  bus
);
    localparam int DW_L    = SINGLE_ENTRY_SIZE_IN_BITS;
    localparam int AW_L    = SET_PTR_WIDTH_IN_BITS;
    localparam int BSZ_L   = BYTE_SIZE_IN_BITS;
    localparam int BYTES_L = DW_L / BSZ_L;
    localparam logic [AW_L-1:0] LAST_SET_L = AW_L'(NUMBER_SETS - 1);
    localparam logic [AW_L:0]   DEPTH_L    = (AW_L + 1)'(NUMBER_SETS);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Addresses at or beyond the depth exist only for non-power-of-two depths.
    function automatic logic in_range(input logic [AW_L-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

`ifdef DUAL_PORT_BLOCKRAM_BYPASS_EN
    // Merge enabled bytes of the new entry over the old stored entry.
    function automatic logic [DW_L-1:0] merge_bytes(input logic [DW_L-1:0] old_entry,
                                                    input logic [DW_L-1:0] new_entry,
                                                    input logic [BYTES_L-1:0] mask);
        logic [DW_L-1:0] res;
        res = old_entry;
        for (int b = 0; b < BYTES_L; b++) begin
            if (mask[b]) begin
                res[b*BSZ_L +: BSZ_L] = new_entry[b*BSZ_L +: BSZ_L];
            end else begin
                res[b*BSZ_L +: BSZ_L] = old_entry[b*BSZ_L +: BSZ_L];
            end
        end
        return res;
    endfunction
`endif

    logic [DW_L-1:0]    mem_q [NUMBER_SETS];
    state_e             state_q, state_d;
    logic [AW_L-1:0]    clr_cnt_q, clr_cnt_d;
    logic               init_done_q, init_done_d;
    logic               rd0_vld_q, rd0_vld_d;
    logic [DW_L-1:0]    rd0_data_q, rd0_data_d;
    logic               out_vld_q, out_vld_d;
    logic [DW_L-1:0]    out_data_q, out_data_d;
    logic               pre_vld_s;
    logic [DW_L-1:0]    pre_data_s;
    logic               wr_ok_s, rd_ok_s;
    logic               mem_we_s;
    logic [AW_L-1:0]    mem_addr_s;
    logic [BYTES_L-1:0] mem_be_s;
    logic [DW_L-1:0]    mem_wdata_s;

    assign wr_ok_s = (state_q == ST_READY) && bus.write_en_in && in_range(bus.write_set_addr_in);
    assign rd_ok_s = (state_q == ST_READY) && bus.read_en_in;

    // Sequencer next state and memory write-port selection (clear vs user write).
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        mem_we_s    = 1'b0;
        mem_addr_s  = clr_cnt_q;
        mem_be_s    = '0;
        mem_wdata_s = '0;
        case (state_q)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = clr_cnt_q;
                mem_be_s    = '1;
                mem_wdata_s = '0;
                if (clr_cnt_q == LAST_SET_L) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW_L'(1);
                end
            end
            ST_READY: begin
                if (wr_ok_s) begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = bus.write_set_addr_in;
                    mem_be_s    = bus.write_byte_en_in;
                    mem_wdata_s = bus.write_entry_in;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                state_d   = ST_INIT;
                clr_cnt_d = '0;
            end
        endcase
        init_done_d = (state_d == ST_READY);
    end

    // First read stage: sample the array (old data, or merged data on a collision).
    always_comb begin
        rd0_vld_d  = rd_ok_s;
        rd0_data_d = rd0_data_q;
        if (rd_ok_s) begin
            if (in_range(bus.read_set_addr_in)) begin
`ifdef DUAL_PORT_BLOCKRAM_BYPASS_EN
                if (wr_ok_s && (bus.write_set_addr_in == bus.read_set_addr_in)) begin
                    rd0_data_d = merge_bytes(mem_q[bus.read_set_addr_in],
                                             bus.write_entry_in, bus.write_byte_en_in);
                end else begin
                    rd0_data_d = mem_q[bus.read_set_addr_in];
                end
`else
                rd0_data_d = mem_q[bus.read_set_addr_in];
`endif
            end else begin
                rd0_data_d = '0;
            end
        end else begin
            rd0_data_d = rd0_data_q;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic            rd1_vld_q, rd1_vld_d;
            logic [DW_L-1:0] rd1_data_q, rd1_data_d;

            // Extra pipeline stage for the two-cycle latency build.
            always_comb begin
                rd1_vld_d = rd0_vld_q;
                if (rd0_vld_q) begin
                    rd1_data_d = rd0_data_q;
                end else begin
                    rd1_data_d = rd1_data_q;
                end
            end

            // Extra pipeline stage registers.
            always_ff @(posedge clk_in or negedge reset_n_in) begin
                if (!reset_n_in) begin
                    rd1_vld_q  <= 1'b0;
                    rd1_data_q <= '0;
                end else begin
                    rd1_vld_q  <= rd1_vld_d;
                    rd1_data_q <= rd1_data_d;
                end
            end

            assign pre_vld_s  = rd1_vld_q;
            assign pre_data_s = rd1_data_q;
        end else begin : g_lat1
            assign pre_vld_s  = rd0_vld_q;
            assign pre_data_s = rd0_data_q;
        end
    endgenerate

    // Output register: one-cycle valid pulse, data held between reads.
    always_comb begin
        out_vld_d = pre_vld_s;
        if (pre_vld_s) begin
            out_data_d = pre_data_s;
        end else begin
            out_data_d = out_data_q;
        end
    end

    // Control and read-pipeline registers; reset drops any in-flight read.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rd0_vld_q   <= 1'b0;
            rd0_data_q  <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rd0_vld_q   <= rd0_vld_d;
            rd0_data_q  <= rd0_data_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage array: byte-masked write, no reset (cleared by the sequencer).
    always_ff @(posedge clk_in) begin
        for (int b = 0; b < BYTES_L; b++) begin
            if (mem_we_s && mem_be_s[b]) begin
                mem_q[mem_addr_s][b*BSZ_L +: BSZ_L] <= mem_wdata_s[b*BSZ_L +: BSZ_L];
            end
        end
    end

    assign bus.init_done_out  = init_done_q;
    assign bus.read_valid_out = out_vld_q;
    assign bus.read_entry_out = out_data_q;
endmodule

// File: tb/tb_dual_port_blockram.sv
// Directed bench for dual_port_blockram: a 64x64b latency-1 instance (main),
// a latency-2 instance and a 5-set instance sharing the same stimulus.
module tb_dual_port_blockram;
    logic clk_in     = 1'b0;
    logic reset_n_in = 1'b0;
    int   cmp_cnt    = 0;
    int   err_cnt    = 0;
    int   cycles;
    logic seen_valid;

    always #5 clk_in = ~clk_in;

    dual_port_blockram_if #(.SINGLE_ENTRY_SIZE_IN_BITS(64), .NUMBER_SETS(64), .BYTE_SIZE_IN_BITS(8)) bus1();
    dual_port_blockram_if #(.SINGLE_ENTRY_SIZE_IN_BITS(64), .NUMBER_SETS(64), .BYTE_SIZE_IN_BITS(8)) bus2();
    dual_port_blockram_if #(.SINGLE_ENTRY_SIZE_IN_BITS(64), .NUMBER_SETS(5),  .BYTE_SIZE_IN_BITS(8)) bus3();

    assign bus2.write_en_in       = bus1.write_en_in;
    assign bus2.write_set_addr_in = bus1.write_set_addr_in;
    assign bus2.write_byte_en_in  = bus1.write_byte_en_in;
    assign bus2.write_entry_in    = bus1.write_entry_in;
    assign bus2.read_en_in        = bus1.read_en_in;
    assign bus2.read_set_addr_in  = bus1.read_set_addr_in;
    assign bus3.write_en_in       = bus1.write_en_in;
    assign bus3.write_set_addr_in = bus1.write_set_addr_in[2:0];
    assign bus3.write_byte_en_in  = bus1.write_byte_en_in;
    assign bus3.write_entry_in    = bus1.write_entry_in;
    assign bus3.read_en_in        = bus1.read_en_in;
    assign bus3.read_set_addr_in  = bus1.read_set_addr_in[2:0];

    dual_port_blockram #(.SINGLE_ENTRY_SIZE_IN_BITS(64), .NUMBER_SETS(64), .BYTE_SIZE_IN_BITS(8),
                         .READ_LATENCY(1)) dut (.clk_in(clk_in), .reset_n_in(reset_n_in), .bus(bus1));
    dual_port_blockram #(.SINGLE_ENTRY_SIZE_IN_BITS(64), .NUMBER_SETS(64), .BYTE_SIZE_IN_BITS(8),
                         .READ_LATENCY(2)) dut_l2 (.clk_in(clk_in), .reset_n_in(reset_n_in), .bus(bus2));
    dual_port_blockram #(.SINGLE_ENTRY_SIZE_IN_BITS(64), .NUMBER_SETS(5), .BYTE_SIZE_IN_BITS(8),
                         .READ_LATENCY(1)) dut_s5 (.clk_in(clk_in), .reset_n_in(reset_n_in), .bus(bus3));

`ifdef DUAL_PORT_BLOCKRAM_BYPASS_EN
    localparam logic [63:0] COLL_FULL = 64'hAAAAAAAA_AAAAAAAA;
    localparam logic [63:0] COLL_PART = 64'h55555555_AAAAAAAA;
`else
    localparam logic [63:0] COLL_FULL = 64'h55555555_55555555;
    localparam logic [63:0] COLL_PART = 64'h55555555_55555555;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [63:0] data, input logic [7:0] mask);
        bus1.write_en_in       = 1'b1;
        bus1.write_set_addr_in = addr;
        bus1.write_entry_in    = data;
        bus1.write_byte_en_in  = mask;
        step();
        bus1.write_en_in       = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [63:0] exp, input string tag);
        bus1.read_en_in       = 1'b1;
        bus1.read_set_addr_in = addr;
        step();
        bus1.read_en_in       = 1'b0;
        step();
        check({tag, "_valid"}, {63'd0, bus1.read_valid_out}, 64'd1);
        check(tag, bus1.read_entry_out, exp);
    endtask

    task automatic wait_init(input string tag);
        cycles     = 0;
        seen_valid = 1'b0;
        while (cycles < 200 && !bus1.init_done_out) begin
            step();
            cycles++;
            if (bus1.read_valid_out) begin
                seen_valid = 1'b1;
            end
        end
        check({tag, "_cycles"}, 64'(cycles), 64'd64);
        check({tag, "_no_valid"}, {63'd0, seen_valid}, 64'd0);
        check({tag, "_l2_done"}, {63'd0, bus2.init_done_out}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus1.write_en_in       = 1'b0;
        bus1.write_set_addr_in = 6'd0;
        bus1.write_byte_en_in  = 8'h00;
        bus1.write_entry_in    = 64'd0;
        bus1.read_en_in        = 1'b0;
        bus1.read_set_addr_in  = 6'd0;

        // Reset state
        #2;
        check("rst_init_done", {63'd0, bus1.init_done_out}, 64'd0);
        check("rst_valid", {63'd0, bus1.read_valid_out}, 64'd0);
        check("rst_data", bus1.read_entry_out, 64'd0);
        repeat (3) step();

        // 1: init takes 64 cycles, reads ignored meanwhile
        reset_n_in            = 1'b1;
        bus1.read_en_in       = 1'b1;
        bus1.read_set_addr_in = 6'd0;
        wait_init("init1");
        bus1.read_en_in = 1'b0;
        step();
        check("init_end_no_valid", {63'd0, bus1.read_valid_out}, 64'd0);
        do_read(6'd0,  64'd0, "clr_set0");
        do_read(6'd31, 64'd0, "clr_set31");
        do_read(6'd63, 64'd0, "clr_set63");

        // 2: full write then read
        do_write(6'd63, 64'hFFFFFFFF_00000000, 8'hFF);
        do_read(6'd63, 64'hFFFFFFFF_00000000, "wr_full");
        step();
        check("pulse_drop", {63'd0, bus1.read_valid_out}, 64'd0);
        check("data_hold", bus1.read_entry_out, 64'hFFFFFFFF_00000000);

        // 3: byte masks
        do_write(6'd63, 64'h01234567_89ABCDEF, 8'h0F);
        do_read(6'd63, 64'hFFFFFFFF_89ABCDEF, "wr_mask0f");
        do_write(6'd63, 64'h0, 8'h00);
        do_read(6'd63, 64'hFFFFFFFF_89ABCDEF, "wr_mask00");

        // 4: same-address collisions
        do_write(6'd5, 64'h55555555_55555555, 8'hFF);
        bus1.write_en_in = 1'b1; bus1.write_set_addr_in = 6'd5;
        bus1.write_entry_in = 64'hAAAAAAAA_AAAAAAAA; bus1.write_byte_en_in = 8'hFF;
        bus1.read_en_in = 1'b1; bus1.read_set_addr_in = 6'd5;
        step();
        bus1.write_en_in = 1'b0; bus1.read_en_in = 1'b0;
        step();
        check("coll_full", bus1.read_entry_out, COLL_FULL);
        do_read(6'd5, 64'hAAAAAAAA_AAAAAAAA, "coll_full_after");
        do_write(6'd6, 64'h55555555_55555555, 8'hFF);
        bus1.write_en_in = 1'b1; bus1.write_set_addr_in = 6'd6;
        bus1.write_entry_in = 64'hAAAAAAAA_AAAAAAAA; bus1.write_byte_en_in = 8'h0F;
        bus1.read_en_in = 1'b1; bus1.read_set_addr_in = 6'd6;
        step();
        bus1.write_en_in = 1'b0; bus1.read_en_in = 1'b0;
        step();
        check("coll_part", bus1.read_entry_out, COLL_PART);
        do_read(6'd6, 64'h55555555_AAAAAAAA, "coll_part_after");

        // Different addresses in the same cycle are independent
        bus1.write_en_in = 1'b1; bus1.write_set_addr_in = 6'd7;
        bus1.write_entry_in = 64'h11111111_11111111; bus1.write_byte_en_in = 8'hFF;
        bus1.read_en_in = 1'b1; bus1.read_set_addr_in = 6'd6;
        step();
        bus1.write_en_in = 1'b0; bus1.read_en_in = 1'b0;
        step();
        check("indep_read", bus1.read_entry_out, 64'h55555555_AAAAAAAA);
        do_read(6'd7, 64'h11111111_11111111, "indep_write");

        // Out-of-range on the 5-set instance (addresses 12 -> 4, 13 -> 5)
        do_write(6'd12, 64'hC0FFEE00_12345678, 8'hFF);
        do_write(6'd13, 64'hDEADBEEF_DEADBEEF, 8'hFF);
        do_read(6'd12, 64'hC0FFEE00_12345678, "s64_set12");
        check("s5_last_set", bus3.read_entry_out, 64'hC0FFEE00_12345678);
        do_read(6'd13, 64'hDEADBEEF_DEADBEEF, "s64_set13");
        check("s5_oor_valid", {63'd0, bus3.read_valid_out}, 64'd1);
        check("s5_oor_data", bus3.read_entry_out, 64'd0);

        // 5: latency-2 instance, back-to-back reads
        do_write(6'd1, 64'h1111_0000_0000_0001, 8'hFF);
        do_write(6'd2, 64'h2222_0000_0000_0002, 8'hFF);
        do_write(6'd3, 64'h3333_0000_0000_0003, 8'hFF);
        bus1.read_en_in = 1'b1; bus1.read_set_addr_in = 6'd1;
        step();
        check("l2_e1_valid", {63'd0, bus2.read_valid_out}, 64'd0);
        bus1.read_set_addr_in = 6'd2;
        step();
        check("l2_e2_valid", {63'd0, bus2.read_valid_out}, 64'd0);
        check("l1_b2b_1", bus1.read_entry_out, 64'h1111_0000_0000_0001);
        bus1.read_set_addr_in = 6'd3;
        step();
        bus1.read_en_in = 1'b0;
        check("l2_e3_valid", {63'd0, bus2.read_valid_out}, 64'd1);
        check("l2_e3_data", bus2.read_entry_out, 64'h1111_0000_0000_0001);
        check("l1_b2b_2", bus1.read_entry_out, 64'h2222_0000_0000_0002);
        step();
        check("l2_e4_valid", {63'd0, bus2.read_valid_out}, 64'd1);
        check("l2_e4_data", bus2.read_entry_out, 64'h2222_0000_0000_0002);
        check("l1_b2b_3", bus1.read_entry_out, 64'h3333_0000_0000_0003);
        step();
        check("l2_e5_valid", {63'd0, bus2.read_valid_out}, 64'd1);
        check("l2_e5_data", bus2.read_entry_out, 64'h3333_0000_0000_0003);
        step();
        check("l2_e6_valid", {63'd0, bus2.read_valid_out}, 64'd0);
        check("l2_e6_hold", bus2.read_entry_out, 64'h3333_0000_0000_0003);

        // 6: reset in the middle of a read burst
        bus1.read_en_in = 1'b1; bus1.read_set_addr_in = 6'd63;
        step();
        step();
        check("burst_valid", {63'd0, bus1.read_valid_out}, 64'd1);
        reset_n_in = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, bus1.read_valid_out}, 64'd0);
        check("mid_rst_l2_valid", {63'd0, bus2.read_valid_out}, 64'd0);
        check("mid_rst_init_done", {63'd0, bus1.init_done_out}, 64'd0);
        check("mid_rst_data", bus1.read_entry_out, 64'd0);
        step();
        step();
        reset_n_in = 1'b1;
        wait_init("init2");
        bus1.read_en_in = 1'b0;
        step();
        do_read(6'd63, 64'd0, "reinit_set63");
        do_read(6'd5,  64'd0, "reinit_set5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
